// File: rtl/mlp_output_layer_seq_pkg.sv
// Shared types and sizing helpers for the MLP output layer.
package mlp_output_layer_seq_pkg;

  // Controller states: accept, activate, multiply-accumulate, present result
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACT  = 2'd1,
    S_MAC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Raw hidden score width: W plus headroom from the hidden layer
  function automatic int unsigned hraw_w(input int unsigned w);
    return w + 5;
  endfunction

  // Accumulator width large enough for bias plus N full products
  function automatic int unsigned acc_w(input int unsigned w, input int unsigned n);
    return 2 * w + 5 + clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mlp_mac_lane.sv
// One class accumulator: bias load, signed MAC step and saturated score.
module mlp_mac_lane
  import mlp_output_layer_seq_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned HRAW_W = 13,
  parameter int unsigned ACC_W  = 25,
  parameter int unsigned OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [W-1:0]      bias,
  input  logic [W-1:0]      weight,
  input  logic [HRAW_W-1:0] h_act,
  output logic [OUT_W-1:0]  sat_c
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0]    acc;
  logic signed [W+HRAW_W-1:0] prod;

  // Full-width signed product, no truncation
  assign prod = $signed(weight) * $signed(h_act);

  // Accumulator: bias preload at job start, one product per MAC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'($signed(bias));
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  // Clamp the accumulator into the signed output range
  always_comb begin
    sat_c = acc[OUT_W-1:0];
    if (acc > MAX_V) begin
      sat_c = MAX_V[OUT_W-1:0];
    end else if (acc < MIN_V) begin
      sat_c = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mlp_output_layer_seq.sv
// Sequential MLP output layer: ReLU, time-multiplexed MAC over hidden units,
// per-class bias and saturation, argmax, valid/ready result.
// Build option: define MLP_OUT_LEAKY_EN for leaky ReLU (h<0 -> h>>>3).
module mlp_output_layer_seq
  import mlp_output_layer_seq_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned C     = 2,
  parameter int unsigned OUT_W = 16,
  localparam int unsigned HRAW_W = hraw_w(W),
  localparam int unsigned CW     = clog2(C)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*HRAW_W-1:0]   h_raw_bus,
  input  logic [C*N*W-1:0]      w_o_bus,
  input  logic [C*W-1:0]        b_o_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [C*OUT_W-1:0]    y_score_bus,
  output logic [CW-1:0]         y_class,
  output logic [N*HRAW_W-1:0]   h_act_bus
);

  localparam int unsigned ACC_W = acc_w(W, N);
  localparam int unsigned KW    = (clog2(N) > 0) ? clog2(N) : 1;

  state_t                    state;
  logic [KW-1:0]             k;
  logic signed [HRAW_W-1:0]  h_raw_q [N];
  logic signed [HRAW_W-1:0]  h_act_q [N];
  logic signed [HRAW_W-1:0]  h_relu_c [N];
  logic signed [W-1:0]       w_q [C][N];
  logic signed [W-1:0]       b_q [C];
  logic [OUT_W-1:0]          lane_sat [C];
  logic [OUT_W-1:0]          best_c;
  logic [CW-1:0]             cls_c;
  logic                      lane_load_c;
  logic                      lane_en_c;
  logic [HRAW_W-1:0]         h_sel_c;

  assign lane_load_c = (state == S_ACT);
  assign lane_en_c   = (state == S_MAC);
  assign h_sel_c     = h_act_q[k];

  // Activation of the latched raw scores
  always_comb begin
    for (int i = 0; i < N; i++) begin
      h_relu_c[i] = h_raw_q[i];
      if (h_raw_q[i][HRAW_W-1]) begin
`ifdef MLP_OUT_LEAKY_EN
        h_relu_c[i] = h_raw_q[i] >>> 3;
`else
        h_relu_c[i] = '0;
`endif
      end
    end
  end

  // One accumulator lane per class, all fed the same hidden unit each cycle
  for (genvar c = 0; c < C; c++) begin : g_lane
    mlp_mac_lane #(
      .W      (W),
      .HRAW_W (HRAW_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (lane_load_c),
      .en     (lane_en_c),
      .bias   (b_q[c]),
      .weight (w_q[c][k]),
      .h_act  (h_sel_c),
      .sat_c  (lane_sat[c])
    );
  end

  // Argmax over saturated scores; strict compare keeps the lowest index on ties
  always_comb begin
    best_c = lane_sat[0];
    cls_c  = '0;
    for (int c = 1; c < C; c++) begin
      if ($signed(lane_sat[c]) > $signed(best_c)) begin
        best_c = lane_sat[c];
        cls_c  = CW'(c);
      end
    end
  end

  // Activated values are exposed directly from their registers
  for (genvar i = 0; i < N; i++) begin : g_act
    assign h_act_bus[i*HRAW_W +: HRAW_W] = h_act_q[i];
  end

  // Controller, input latches, activation and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      k           <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      y_score_bus <= '0;
      y_class     <= '0;
      for (int i = 0; i < N; i++) begin
        h_raw_q[i] <= '0;
        h_act_q[i] <= '0;
      end
      for (int c = 0; c < C; c++) begin
        b_q[c] <= '0;
        for (int i = 0; i < N; i++) w_q[c][i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            state    <= S_ACT;
            for (int i = 0; i < N; i++) begin
              h_raw_q[i] <= h_raw_bus[i*HRAW_W +: HRAW_W];
            end
            for (int c = 0; c < C; c++) begin
              b_q[c] <= b_o_bus[c*W +: W];
              for (int i = 0; i < N; i++) begin
                w_q[c][i] <= w_o_bus[(c*N+i)*W +: W];
              end
            end
          end
        end
        S_ACT: begin
          for (int i = 0; i < N; i++) h_act_q[i] <= h_relu_c[i];
          k     <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          if (k == KW'(N - 1)) begin
            state <= S_DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            y_class   <= cls_c;
            for (int c = 0; c < C; c++) begin
              y_score_bus[c*OUT_W +: OUT_W] <= lane_sat[c];
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_output_layer_seq.sv
// Self-checking bench for mlp_output_layer_seq against a plain-arithmetic model.
module tb_mlp_output_layer_seq;

  localparam int unsigned W     = 8;
  localparam int unsigned N     = 8;
  localparam int unsigned C     = 2;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned HW    = W + 5;
  localparam int unsigned CW    = 1;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*HW-1:0]      h_raw_bus;
  logic [C*N*W-1:0]     w_o_bus;
  logic [C*W-1:0]       b_o_bus;
  logic                 out_valid;
  logic                 out_ready;
  logic [C*OUT_W-1:0]   y_score_bus;
  logic [CW-1:0]        y_class;
  logic [N*HW-1:0]      h_act_bus;

  int vectors;
  int miscompares;
  int hv [N];
  int wv [C][N];
  int bv [C];
  int exp_y [C];
  int exp_cls;
  int exp_act [N];

  mlp_output_layer_seq #(.W(W), .N(N), .C(C), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .h_raw_bus   (h_raw_bus),
    .w_o_bus     (w_o_bus),
    .b_o_bus     (b_o_bus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y_score_bus (y_score_bus),
    .y_class     (y_class),
    .h_act_bus   (h_act_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int h, input int w0, input int w1, input int b0, input int b1);
    for (int i = 0; i < N; i++) begin
      hv[i] = h;
      wv[0][i] = w0;
      wv[1][i] = w1;
    end
    bv[0] = b0;
    bv[1] = b1;
  endtask

  task automatic pack_bus();
    for (int i = 0; i < N; i++) h_raw_bus[i*HW +: HW] = HW'(hv[i]);
    for (int c = 0; c < C; c++) begin
      b_o_bus[c*W +: W] = W'(bv[c]);
      for (int i = 0; i < N; i++) w_o_bus[(c*N+i)*W +: W] = W'(wv[c][i]);
    end
  endtask

  // Reference: activation, dot product plus bias, clamp, first-maximum argmax
  task automatic model();
    longint acc;
    int best;
    for (int i = 0; i < N; i++) begin
      if (hv[i] >= 0) exp_act[i] = hv[i];
      else begin
`ifdef MLP_OUT_LEAKY_EN
        exp_act[i] = (hv[i] - 7) / 8;
`else
        exp_act[i] = 0;
`endif
      end
    end
    for (int c = 0; c < C; c++) begin
      acc = longint'(bv[c]);
      for (int i = 0; i < N; i++) acc += longint'(wv[c][i]) * longint'(exp_act[i]);
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      exp_y[c] = int'(acc);
    end
    best = 0;
    for (int c = 1; c < C; c++) if (exp_y[c] > exp_y[best]) best = c;
    exp_cls = best;
  endtask

  // Present the bundle and return just after the accepting edge; in_valid stays high
  task automatic accept_job();
    int g;
    pack_bus();
    in_valid = 1'b1;
    g = 0;
    while (in_ready !== 1'b1 && g < 50) begin
      step();
      g++;
    end
    if (g >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, g);
    end
    step();
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    vectors++;
    if (y_score_bus !== '0 || y_class !== '0 || h_act_bus !== '0) begin
      miscompares++;
      $display("FAIL reset_data: y=%h cls=%h act=%h, required all 0", y_score_bus, y_class, h_act_bus);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    fill(10, 1, 2, 0, 0);
    model();
    accept_job();
    in_valid = 1'b0;
    wait_result(lat);
    vectors++;
    if (lat != N + 2) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d edges, required %0d", lat, N + 2);
    end
    for (int c = 0; c < C; c++) begin
      vectors++;
      if (y_score_bus[c*OUT_W +: OUT_W] !== OUT_W'(exp_y[c])) begin
        miscompares++;
        $display("FAIL basic_y%0d: got %0d, required %0d", c, $signed(y_score_bus[c*OUT_W +: OUT_W]), exp_y[c]);
      end
    end
    vectors++;
    if (y_class !== CW'(exp_cls)) begin
      miscompares++;
      $display("FAIL basic_class: got %0d, required %0d", y_class, exp_cls);
    end
    consume();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_negative();
    int lat;
    fill(-20, 1, 1, 5, -3);
    model();
    accept_job();
    in_valid = 1'b0;
    wait_result(lat);
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (h_act_bus[i*HW +: HW] !== HW'(exp_act[i])) begin
        miscompares++;
        $display("FAIL neg_act%0d: got %0d, required %0d", i, $signed(h_act_bus[i*HW +: HW]), exp_act[i]);
      end
    end
    for (int c = 0; c < C; c++) begin
      vectors++;
      if (y_score_bus[c*OUT_W +: OUT_W] !== OUT_W'(exp_y[c])) begin
        miscompares++;
        $display("FAIL neg_y%0d: got %0d, required %0d", c, $signed(y_score_bus[c*OUT_W +: OUT_W]), exp_y[c]);
      end
    end
    vectors++;
    if (y_class !== CW'(exp_cls)) begin
      miscompares++;
      $display("FAIL neg_class: got %0d, required %0d", y_class, exp_cls);
    end
    consume();
  endtask

  task automatic test_saturation();
    int lat;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) fill(4095, 127, 127, 127, 127);
      else        fill(4095, -128, -128, -128, -128);
      model();
      accept_job();
      in_valid = 1'b0;
      wait_result(lat);
      for (int c = 0; c < C; c++) begin
        vectors++;
        if (y_score_bus[c*OUT_W +: OUT_W] !== OUT_W'(exp_y[c])) begin
          miscompares++;
          $display("FAIL sat%0d_y%0d: got %0d, required %0d", s, c, $signed(y_score_bus[c*OUT_W +: OUT_W]), exp_y[c]);
        end
      end
      vectors++;
      if (y_class !== CW'(exp_cls)) begin
        miscompares++;
        $display("FAIL sat%0d_class: got %0d, required %0d", s, y_class, exp_cls);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int ea [C];
    int ecls;
    fill(33, -4, 9, 12, -7);
    model();
    accept_job();
    in_valid = 1'b0;
    wait_result(lat);
    for (int c = 0; c < C; c++) ea[c] = exp_y[c];
    ecls = exp_cls;
    fill(7, 3, 1, -2, 4);
    pack_bus();
    in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b, required 1 0", t, out_valid, in_ready);
      end
      for (int c = 0; c < C; c++) begin
        vectors++;
        if (y_score_bus[c*OUT_W +: OUT_W] !== OUT_W'(ea[c])) begin
          miscompares++;
          $display("FAIL bp_y%0d_t%0d: got %0d, required %0d", c, t, $signed(y_score_bus[c*OUT_W +: OUT_W]), ea[c]);
        end
      end
      vectors++;
      if (y_class !== CW'(ecls)) begin
        miscompares++;
        $display("FAIL bp_class_t%0d: got %0d, required %0d", t, y_class, ecls);
      end
      step();
    end
    consume();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    model();
    accept_job();
    in_valid = 1'b0;
    wait_result(lat);
    vectors++;
    if (lat != N + 2) begin
      miscompares++;
      $display("FAIL bp_second_latency: got %0d, required %0d", lat, N + 2);
    end
    for (int c = 0; c < C; c++) begin
      vectors++;
      if (y_score_bus[c*OUT_W +: OUT_W] !== OUT_W'(exp_y[c])) begin
        miscompares++;
        $display("FAIL bp_second_y%0d: got %0d, required %0d", c, $signed(y_score_bus[c*OUT_W +: OUT_W]), exp_y[c]);
      end
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    fill(10, 1, 2, 0, 0);
    model();
    accept_job();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || y_score_bus !== '0 || y_class !== '0 || h_act_bus !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear: ov=%b rdy=%b y=%h cls=%h act=%h, required all 0",
               out_valid, in_ready, y_score_bus, y_class, h_act_bus);
    end
    step();
    rst = 1'b0;
    step();
    accept_job();
    in_valid = 1'b0;
    wait_result(lat);
    vectors++;
    if (lat != N + 2) begin
      miscompares++;
      $display("FAIL midreset_latency: got %0d, required %0d", lat, N + 2);
    end
    for (int c = 0; c < C; c++) begin
      vectors++;
      if (y_score_bus[c*OUT_W +: OUT_W] !== OUT_W'(exp_y[c])) begin
        miscompares++;
        $display("FAIL midreset_y%0d: got %0d, required %0d", c, $signed(y_score_bus[c*OUT_W +: OUT_W]), exp_y[c]);
      end
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    int ea [C];
    fill(25, 2, -1, 3, 0);
    model();
    for (int c = 0; c < C; c++) ea[c] = exp_y[c];
    out_ready = 1'b1;
    accept_job();
    fill(-9, 5, 5, -1, 6);
    for (int i = 0; i < N; i += 2) hv[i] = 40 + i;
    pack_bus();
    model();
    wait_result(lat);
    vectors++;
    if (lat != N + 2) begin
      miscompares++;
      $display("FAIL b2b_first_latency: got %0d, required %0d", lat, N + 2);
    end
    for (int c = 0; c < C; c++) begin
      vectors++;
      if (y_score_bus[c*OUT_W +: OUT_W] !== OUT_W'(ea[c])) begin
        miscompares++;
        $display("FAIL b2b_first_y%0d: got %0d, required %0d", c, $signed(y_score_bus[c*OUT_W +: OUT_W]), ea[c]);
      end
    end
    accept_job();
    in_valid = 1'b0;
    wait_result(lat);
    vectors++;
    if (lat != N + 2) begin
      miscompares++;
      $display("FAIL b2b_second_latency: got %0d, required %0d", lat, N + 2);
    end
    for (int c = 0; c < C; c++) begin
      vectors++;
      if (y_score_bus[c*OUT_W +: OUT_W] !== OUT_W'(exp_y[c])) begin
        miscompares++;
        $display("FAIL b2b_second_y%0d: got %0d, required %0d", c, $signed(y_score_bus[c*OUT_W +: OUT_W]), exp_y[c]);
      end
    end
    vectors++;
    if (y_class !== CW'(exp_cls)) begin
      miscompares++;
      $display("FAIL b2b_second_class: got %0d, required %0d", y_class, exp_cls);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    int d;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < N; i++) begin
        hv[i] = int'($urandom_range(8191)) - 4096;
        for (int c = 0; c < C; c++) wv[c][i] = int'($urandom_range(255)) - 128;
      end
      for (int c = 0; c < C; c++) bv[c] = int'($urandom_range(255)) - 128;
      model();
      accept_job();
      in_valid = 1'b0;
      wait_result(lat);
      vectors++;
      if (lat != N + 2) begin
        miscompares++;
        $display("FAIL rnd%0d_latency: got %0d, required %0d", n, lat, N + 2);
      end
      d = int'($urandom_range(3));
      repeat (d) step();
      for (int c = 0; c < C; c++) begin
        vectors++;
        if (y_score_bus[c*OUT_W +: OUT_W] !== OUT_W'(exp_y[c])) begin
          miscompares++;
          $display("FAIL rnd%0d_y%0d: got %0d, required %0d", n, c, $signed(y_score_bus[c*OUT_W +: OUT_W]), exp_y[c]);
        end
      end
      vectors++;
      if (y_class !== CW'(exp_cls) || h_act_bus[0 +: HW] !== HW'(exp_act[0])) begin
        miscompares++;
        $display("FAIL rnd%0d_class_act: cls %0d act0 %0d, required %0d %0d",
                 n, y_class, $signed(h_act_bus[0 +: HW]), exp_cls, exp_act[0]);
      end
      consume();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    h_raw_bus   = '0;
    w_o_bus     = '0;
    b_o_bus     = '0;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
